// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared types and note table for the tone request player
// Purpose: FSM state type, phase counter width and the half-period lookup
//          (in 48 kHz sample periods) for note codes 1..15.
// Ports:   none (package)
package tone_pkg;

  typedef enum logic {REQ, PLAY} state_t;

  localparam int PHASE_W = 7;

  // Samples per half cycle of the square wave. Code 0 is a rest and never
  // advances the phase counter, so its entry is unused.
  function automatic logic [PHASE_W-1:0] half_period(input logic [3:0] code);
    case (code)
      4'd1:    half_period = 7'd92;  // C4
      4'd2:    half_period = 7'd82;  // D4
      4'd3:    half_period = 7'd73;  // E4
      4'd4:    half_period = 7'd69;  // F4
      4'd5:    half_period = 7'd61;  // G4
      4'd6:    half_period = 7'd55;  // A4
      4'd7:    half_period = 7'd49;  // B4
      4'd8:    half_period = 7'd46;  // C5
      4'd9:    half_period = 7'd41;  // D5
      4'd10:   half_period = 7'd36;  // E5
      4'd11:   half_period = 7'd34;  // F5
      4'd12:   half_period = 7'd31;  // G5
      4'd13:   half_period = 7'd27;  // A5
      4'd14:   half_period = 7'd24;  // B5
      4'd15:   half_period = 7'd23;  // C6
      default: half_period = 7'd1;
    endcase
  endfunction

endpackage

// File: rtl/square_osc.sv
// rtl/square_osc.sv - square-wave oscillator with one-cycle sample latency
// Purpose: phase counter, polarity flip-flop and output sample mux.
// Ports:   i_clk, i_rst_n      clock / async active-low reset
//          i_sample_req        one-cycle pulse per codec sample slot
//          i_load              restart phase for a newly accepted note
//          i_code              current note code (0 = rest)
//          o_sample            signed sample, held between pulses
//          o_sample_valid      one-cycle pulse, sample updated
module square_osc
  import tone_pkg::*;
#(
  parameter int                          SAMPLE_W  = 24,
  parameter logic signed [SAMPLE_W-1:0]  AMPLITUDE = 24'sd2000000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_sample_req,
  input  logic                       i_load,
  input  logic [3:0]                 i_code,
  output logic signed [SAMPLE_W-1:0] o_sample,
  output logic                       o_sample_valid
);

  logic [PHASE_W-1:0]         r_phase_cnt;
  logic                       r_polarity;
  logic signed [SAMPLE_W-1:0] r_sample;
  logic                       r_sample_valid;

  logic [PHASE_W-1:0]         w_half_last;
  logic signed [SAMPLE_W-1:0] w_level;

  assign w_half_last = half_period(i_code) - 7'd1;
  assign w_level     = (i_code == 4'd0) ? '0 : (r_polarity ? AMPLITUDE : -AMPLITUDE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase_cnt    <= '0;
      r_polarity     <= 1'b1;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= i_sample_req;
      // The emitted sample always reflects the note/polarity before this edge,
      // even when a new note is loaded on the same edge.
      if (i_sample_req) r_sample <= w_level;
      if (i_load) begin
        r_phase_cnt <= '0;
        r_polarity  <= 1'b1;
      end else if (i_sample_req && (i_code != 4'd0)) begin
        if (r_phase_cnt == w_half_last) begin
          r_phase_cnt <= '0;
          r_polarity  <= ~r_polarity;
        end else begin
          r_phase_cnt <= r_phase_cnt + 7'd1;
        end
      end
    end
  end

  assign o_sample       = r_sample;
  assign o_sample_valid = r_sample_valid;

endmodule

// File: rtl/tone_request_player.sv
// rtl/tone_request_player.sv - note request/ready consumer driving a square-wave tone
// Purpose: requests a note code, latches it on data_rd, plays it for
//          NOTE_SAMPLES sample periods, then requests again while the
//          previous note keeps sounding.
// Ports:   CLOCK_50, resetn  clock / async active-low reset
//          sample_req        codec sample slot pulse
//          sound_code        note code (0 = rest), valid while data_rd
//          data_rd           source ready
//          data_rq           request for next note code
//          sample            signed output sample
//          sample_valid      one-cycle pulse per produced sample
module tone_request_player
  import tone_pkg::*;
#(
  parameter int                          SAMPLE_W     = 24,
  parameter logic signed [SAMPLE_W-1:0]  AMPLITUDE    = 24'sd2000000,
  parameter int                          NOTE_SAMPLES = 12000
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic                       sample_req,
  input  logic [3:0]                 sound_code,
  input  logic                       data_rd,
  output logic                       data_rq,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid
);

  localparam int             DUR_W    = $clog2(NOTE_SAMPLES);
  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_SAMPLES - 1);

  state_t           r_state;
  logic             r_data_rq;
  logic [3:0]       r_cur_code;
  logic [DUR_W-1:0] r_dur_cnt;
  logic             w_accept;

  // data_rq is only ever high in REQ, so it alone qualifies the handshake.
  assign w_accept = r_data_rq & data_rd;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state    <= REQ;
      r_data_rq  <= 1'b0;
      r_cur_code <= 4'd0;
      r_dur_cnt  <= '0;
    end else begin
      case (r_state)
        REQ: begin
          if (w_accept) begin
            r_cur_code <= sound_code;
            r_dur_cnt  <= '0;
            r_data_rq  <= 1'b0;
            r_state    <= PLAY;
          end else begin
            r_data_rq  <= 1'b1;
          end
        end
        PLAY: begin
          r_data_rq <= 1'b0;
          if (sample_req) begin
            if (r_dur_cnt == DUR_LAST) begin
              r_state   <= REQ;
              r_data_rq <= 1'b1;
            end else begin
              r_dur_cnt <= r_dur_cnt + 1'b1;
            end
          end
        end
        default: r_state <= REQ;
      endcase
    end
  end

  square_osc #(
    .SAMPLE_W  (SAMPLE_W),
    .AMPLITUDE (AMPLITUDE)
  ) u_osc (
    .i_clk          (CLOCK_50),
    .i_rst_n        (resetn),
    .i_sample_req   (sample_req),
    .i_load         (w_accept),
    .i_code         (r_cur_code),
    .o_sample       (sample),
    .o_sample_valid (sample_valid)
  );

  assign data_rq = r_data_rq;

endmodule

// File: tb/tb_tone_request_player.sv
// tb/tb_tone_request_player.sv - self-checking bench for tone_request_player
module tb_tone_request_player;

  localparam int SAMPLE_W = 24;
  localparam int AMP      = 2000000;
  localparam int NS       = 4;

  logic                       CLOCK_50 = 1'b0;
  logic                       resetn   = 1'b0;
  logic                       sample_req = 1'b0;
  logic [3:0]                 sound_code = 4'd0;
  logic                       data_rd  = 1'b0;
  logic                       data_rq;
  logic signed [SAMPLE_W-1:0] sample;
  logic                       sample_valid;

  tone_request_player #(
    .SAMPLE_W     (SAMPLE_W),
    .AMPLITUDE    (24'sd2000000),
    .NOTE_SAMPLES (NS)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .sample_req   (sample_req),
    .sound_code   (sound_code),
    .data_rd      (data_rd),
    .data_rq      (data_rq),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  int tb_half [16] = '{0, 92, 82, 73, 69, 61, 55, 49, 46, 41, 36, 34, 31, 27, 24, 23};

  // Reference model: a note is a sequence of samples indexed k = 0,1,2...;
  // sample k is positive when floor(k / half) is even.
  int exp_rq, exp_valid, exp_sample;
  int m_code, m_k, m_play_n, m_inplay;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int level(input int code, input int k);
    if (code == 0) return 0;
    return (((k / tb_half[code]) % 2) == 0) ? AMP : -AMP;
  endfunction

  task automatic model_reset();
    exp_rq = 0; exp_valid = 0; exp_sample = 0;
    m_code = 0; m_k = 0; m_play_n = 0; m_inplay = 0;
  endtask

  task automatic model_edge(input bit sreq, input bit rd, input int code);
    bit accept;
    accept = (exp_rq != 0) && rd;
    exp_valid = sreq;
    if (sreq) exp_sample = level(m_code, m_k);
    if (accept) begin
      m_code = code; m_k = 0; m_play_n = 0; m_inplay = 1; exp_rq = 0;
    end else begin
      if (sreq && m_code != 0) m_k++;
      if (m_inplay != 0) begin
        if (sreq) begin
          m_play_n++;
          if (m_play_n == NS) begin
            m_inplay = 0;
            exp_rq = 1;
          end
        end
      end else begin
        exp_rq = 1;
      end
    end
  endtask

  task automatic cycle(input bit sreq, input bit rd, input int code);
    sample_req = sreq;
    data_rd    = rd;
    sound_code = 4'(code);
    model_edge(sreq, rd, code);
    @(posedge CLOCK_50);
    #1;
    check_val("data_rq", int'(data_rq), exp_rq);
    check_val("sample_valid", int'(sample_valid), exp_valid);
    check_val("sample", int'(sample), exp_sample);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_val("rst_sample", int'(sample), 0);
    check_val("rst_rq", int'(data_rq), 0);
    check_val("rst_valid", int'(sample_valid), 0);
    resetn = 1'b1;

    // Rest after reset: request rises and stays high, samples are 0.
    for (int i = 0; i < 10; i++) cycle(i % 2 == 0, 0, 0);

    // Short note A4: four positive samples, then request again.
    cycle(0, 1, 6);
    check_val("a4_rq_drop", int'(data_rq), 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0);
      check_val("a4_pos", int'(sample), AMP);
      cycle(0, 0, 0);
    end
    check_val("a4_rq_back", int'(data_rq), 1);
    cycle(1, 0, 0);
    check_val("a4_keeps_sounding", int'(sample), AMP);

    // C6 held: 23 positive then negative; stop 30 pulses in (negative).
    cycle(0, 1, 15);
    for (int i = 0; i < 30; i++) begin
      cycle(1, 0, 0);
      if (i == 22) check_val("c6_last_pos", int'(sample), AMP);
      if (i == 23) check_val("c6_first_neg", int'(sample), -AMP);
    end

    // Accept code 1 together with a sample request while negative.
    cycle(1, 1, 1);
    check_val("coinc_old_note", int'(sample), -AMP);
    cycle(1, 0, 0);
    check_val("coinc_new_note", int'(sample), AMP);
    check_val("coinc_phase", int'(dut.u_osc.r_phase_cnt), 1);

    // data_rd during PLAY is ignored.
    cycle(0, 1, 3);
    check_val("play_rd_ignored_rq", int'(data_rq), 0);
    check_val("play_rd_ignored_code", int'(dut.r_cur_code), 1);

    // Finish note, accept D5, then reset mid-note.
    for (int i = 0; i < 12 && exp_rq == 0; i++) cycle(1, 0, 0);
    check_val("rq_before_d5", int'(data_rq), 1);
    cycle(0, 1, 9);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check_val("d5_pos", int'(sample), AMP);
    sample_req = 1'b0;
    data_rd    = 1'b0;
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    check_val("midrst_sample", int'(sample), 0);
    check_val("midrst_rq", int'(data_rq), 0);
    check_val("midrst_valid", int'(sample_valid), 0);
    @(posedge CLOCK_50);
    #1;
    check_val("midrst_hold_rq", int'(data_rq), 0);
    resetn = 1'b1;
    cycle(0, 0, 0);
    check_val("postrst_rq", int'(data_rq), 1);
    cycle(1, 0, 0);
    check_val("postrst_rest", int'(sample), 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
